// File: rtl/demux_4way_16_buf.sv
// -----------------------------------------------------------------------------
// demux_4way_16_buf
//
// Routes one 16-bit valid/ready input stream to one of four output channels.
// Each channel is a single-entry register with a valid flag. The target channel
// comes from the select lines {S2,S1} when auto_en=0, or from an internal
// round-robin pointer when auto_en=1.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   I, I_valid, I_ready   input stream; I_ready is combinational (free(tgt))
//   S1, S2                manual channel select, tgt = {S2,S1}
//   auto_en               1 = round-robin pointer selects the channel
//   O1..O4                channel data registers
//   O1_valid..O4_valid    channel holds an undelivered word
//   O1_ready..O4_ready    consumer takes the channel word this cycle
//   ptr                   current round-robin pointer
//   acc_cnt               count of accepted words (wraps)
// -----------------------------------------------------------------------------
module demux_4way_16_buf #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] I,
  input  logic             I_valid,
  output logic             I_ready,
  input  logic             S1,
  input  logic             S2,
  input  logic             auto_en,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic [WIDTH-1:0] O4,
  output logic             O1_valid,
  output logic             O2_valid,
  output logic             O3_valid,
  output logic             O4_valid,
  input  logic             O1_ready,
  input  logic             O2_ready,
  input  logic             O3_ready,
  input  logic             O4_ready,
  output logic [1:0]       ptr,
  output logic [CNT_W-1:0] acc_cnt
);

  logic [WIDTH-1:0] r_data [4];
  logic [3:0]       r_valid;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0]       w_out_ready;
  logic [3:0]       w_free;
  logic [1:0]       w_tgt;
  logic             w_accept;

  assign w_out_ready = {O4_ready, O3_ready, O2_ready, O1_ready};

  // A slot is free when empty, or when its word leaves at the same edge the
  // new one arrives; this is what gives 1 word/cycle per channel.
  assign w_free   = ~r_valid | w_out_ready;
  assign w_tgt    = auto_en ? r_ptr : {S2, S1};
  assign I_ready  = w_free[w_tgt];
  assign w_accept = I_valid & I_ready;

  // NOTE: the data registers are reset along with the valid flags because the
  // channel outputs are architecturally defined as zero after reset; a plain
  // buffer that is only read when valid would not need this.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int x = 0; x < 4; x++) begin
        r_data[x] <= '0;
      end
      r_valid <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values regardless of statement order.
      for (int x = 0; x < 4; x++) begin
        if (w_accept && (w_tgt == 2'(x))) begin
          r_data[x]  <= I;
          r_valid[x] <= 1'b1;
        end else if (r_valid[x] && w_out_ready[x]) begin
          // Drain: only the flag drops, the data stays visible.
          r_valid[x] <= 1'b0;
        end
      end
      if (w_accept) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (auto_en) begin
          r_ptr <= r_ptr + 2'd1;
        end
      end
    end
  end

  assign O1       = r_data[0];
  assign O2       = r_data[1];
  assign O3       = r_data[2];
  assign O4       = r_data[3];
  assign O1_valid = r_valid[0];
  assign O2_valid = r_valid[1];
  assign O3_valid = r_valid[2];
  assign O4_valid = r_valid[3];
  assign ptr      = r_ptr;
  assign acc_cnt  = r_cnt;

endmodule

// File: tb/tb_demux_4way_16_buf.sv
// -----------------------------------------------------------------------------
// tb_demux_4way_16_buf
//
// Scoreboard bench. The driver applies one stimulus vector per cycle, predicts
// I_ready from per-channel queues of undelivered words, and pushes each
// predicted accept into that channel's queue. A separate monitor, just before
// each rising edge, pops a word whenever a channel is due to deliver and
// compares it with the DUT channel register.
// -----------------------------------------------------------------------------
module tb_demux_4way_16_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] I = '0;
  logic        I_valid = 1'b0;
  logic        I_ready;
  logic        S1 = 1'b0, S2 = 1'b0, auto_en = 1'b0;
  logic [15:0] O1, O2, O3, O4;
  logic        O1_valid, O2_valid, O3_valid, O4_valid;
  logic        O1_ready = 1'b0, O2_ready = 1'b0, O3_ready = 1'b0, O4_ready = 1'b0;
  logic [1:0]  ptr;
  logic [7:0]  acc_cnt;

  demux_4way_16_buf #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .I(I), .I_valid(I_valid), .I_ready(I_ready),
    .S1(S1), .S2(S2), .auto_en(auto_en),
    .O1(O1), .O2(O2), .O3(O3), .O4(O4),
    .O1_valid(O1_valid), .O2_valid(O2_valid), .O3_valid(O3_valid), .O4_valid(O4_valid),
    .O1_ready(O1_ready), .O2_ready(O2_ready), .O3_ready(O3_ready), .O4_ready(O4_ready),
    .ptr(ptr), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: pending words per channel, pointer and counter as integers.
  logic [15:0] exp_q [4][$];
  int          m_ptr;
  int          m_cnt;
  logic [3:0]  pushed;
  logic        mon_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] o_data(input int x);
    case (x)
      0: return O1;
      1: return O2;
      2: return O3;
      default: return O4;
    endcase
  endfunction

  function automatic logic o_valid(input int x);
    case (x)
      0: return O1_valid;
      1: return O2_valid;
      2: return O3_valid;
      default: return O4_valid;
    endcase
  endfunction

  function automatic logic o_ready(input int x);
    case (x)
      0: return O1_ready;
      1: return O2_ready;
      2: return O3_ready;
      default: return O4_ready;
    endcase
  endfunction

  // One clock cycle of stimulus: drive at negedge+1, predict and check at +2.
  task automatic cycle(input logic v, input logic [15:0] d, input logic [1:0] sel,
                       input logic au, input logic [3:0] rdy);
    int  tgt;
    logic free;
    @(negedge clk);
    #1;
    I_valid = v;
    I       = d;
    {S2, S1} = sel;
    auto_en = au;
    {O4_ready, O3_ready, O2_ready, O1_ready} = rdy;
    #1;
    check("ptr", 32'(ptr), 32'(m_ptr));
    check("acc_cnt", 32'(acc_cnt), 32'(m_cnt));
    tgt  = au ? m_ptr : int'(sel);
    free = (exp_q[tgt].size() == 0) || rdy[tgt];
    check("I_ready", 32'(I_ready), 32'(free));
    pushed = '0;
    if (v && free) begin
      exp_q[tgt].push_back(d);
      pushed[tgt] = 1'b1;
      m_cnt = (m_cnt + 1) % 256;
      if (au) m_ptr = (m_ptr + 1) % 4;
    end
  endtask

  // Monitor: just before the rising edge, check each channel's flag and pop the
  // word that the consumer takes at this edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) begin
        for (int x = 0; x < 4; x++) begin
          int pending;
          pending = exp_q[x].size() - int'(pushed[x]);
          check($sformatf("O%0d_valid", x + 1), 32'(o_valid(x)), 32'(pending > 0));
          if (pending > 0 && o_ready(x)) begin
            check($sformatf("O%0d_data", x + 1), 32'(o_data(x)), 32'(exp_q[x].pop_front()));
          end
        end
      end
      pushed = '0;
    end
  end

  // Asynchronous reset applied between clock edges; checked without an edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    mon_en  = 1'b0;
    I_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("rst_valids", 32'({O4_valid, O3_valid, O2_valid, O1_valid}), 32'h0);
    check("rst_data", {O1, O2} | {O3, O4}, 32'h0);
    check("rst_ptr_cnt", {22'h0, ptr, acc_cnt}, 32'h0);
    for (int x = 0; x < 4; x++) exp_q[x].delete();
    m_ptr  = 0;
    m_cnt  = 0;
    pushed = '0;
    @(negedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    for (int x = 0; x < 4; x++) exp_q[x].delete();
    m_ptr = 0; m_cnt = 0; pushed = '0;
    repeat (2) @(negedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Manual routing, consumers stalled.
    cycle(1, 16'hA001, 2'b00, 0, 4'h0);
    cycle(1, 16'hA002, 2'b01, 0, 4'h0);
    cycle(1, 16'hA003, 2'b10, 0, 4'h0);
    cycle(1, 16'hA004, 2'b11, 0, 4'h0);
    cycle(0, 16'h0000, 2'b00, 0, 4'h0);
    check("route_data", {O1, O2}, 32'hA001_A002);
    check("route_data34", {O3, O4}, 32'hA003_A004);
    check("route_cnt", 32'(acc_cnt), 32'd4);

    // Backpressure on O3 for 5 cycles, then release with same-cycle refill.
    for (int k = 0; k < 5; k++) cycle(1, 16'hB003, 2'b10, 0, 4'h0);
    check("bp_hold", 32'(O3), 32'hA003);
    cycle(1, 16'hB003, 2'b10, 0, 4'b0100);
    cycle(0, 16'h0000, 2'b00, 0, 4'h0);
    check("bp_replace", {15'h0, O3_valid, O3}, {15'h0, 1'b1, 16'hB003});

    // Reset mid-stream with O2 holding a word.
    check("pre_rst_o2", 32'(O2_valid), 32'd1);
    do_reset();

    // Round-robin wrap, consumers always ready.
    for (int k = 0; k < 6; k++) cycle(1, 16'(k), 2'b00, 1, 4'hF);
    cycle(0, 16'h0000, 2'b00, 1, 4'h0);
    check("rr_ptr", 32'(ptr), 32'd2);
    check("rr_last", {O1, O2}, 32'h0004_0005);

    // Pointer hold across manual traffic.
    for (int k = 0; k < 3; k++) cycle(1, 16'hC000 + 16'(k), 2'b00, 0, 4'h1);
    cycle(1, 16'hC0DE, 2'b01, 1, 4'h1);
    cycle(0, 16'h0000, 2'b00, 0, 4'h0);
    check("hold_o3", 32'(O3), 32'hC0DE);
    check("hold_ptr", 32'(ptr), 32'd3);

    // Counter wrap after 256 accepts from reset, then drain O1 without refill.
    do_reset();
    for (int k = 0; k < 256; k++) cycle(1, 16'(k), 2'b00, 1, 4'hF);
    cycle(0, 16'h0000, 2'b00, 0, 4'hF);
    check("cnt_wrap", 32'(acc_cnt), 32'd0);
    cycle(1, 16'hBEEF, 2'b00, 0, 4'h0);
    cycle(0, 16'h0000, 2'b00, 0, 4'h1);
    cycle(0, 16'h0000, 2'b00, 0, 4'h0);
    check("drain_o1", {15'h0, O1_valid, O1}, {15'h0, 1'b0, 16'hBEEF});

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom), 1'($urandom_range(0, 1)),
            4'($urandom));
    end
    // Flush everything still buffered.
    repeat (2) cycle(0, 16'h0000, 2'b00, 0, 4'hF);
    for (int x = 0; x < 4; x++) check($sformatf("q%0d_empty", x + 1), exp_q[x].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_4way_16_buf.md
Name: demux_4way_16_buf

Overview:
- 4-way 16-bit demultiplexer/distributor: the routing inverse of the 4-way 16-bit mux.
- Takes one 16-bit input stream with a valid/ready handshake and delivers each word to one of four buffered output channels.
- The target channel comes either from the select lines (S2,S1) or from an internal round-robin pointer.
- Sits between a single producer and four consumers in the lab datapath.

Parameters:
- WIDTH, 16, data width of the input and of each output channel
- CNT_W, 8, width of the accepted-word counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- I  input  WIDTH  input data word
- I_valid  input  1  input word present
- I_ready  output  1  block accepts I this cycle (combinational)
- S1  input  1  select, low bit of channel index
- S2  input  1  select, high bit of channel index
- auto_en  input  1  1 = round-robin pointer selects the channel, 0 = {S2,S1} selects it
- O1,O2,O3,O4  output  WIDTH each  channel data registers
- O1_valid..O4_valid  output  1 each  channel holds an undelivered word
- O1_ready..O4_ready  input  1 each  consumer takes the channel word this cycle
- ptr  output  2  current round-robin pointer
- acc_cnt  output  CNT_W  count of accepted words

Behaviour:
- Reset (rst_n low, asynchronous):
  - O1..O4 = 0, all Ox_valid = 0, ptr = 0, acc_cnt = 0.
  - Any buffered words are discarded immediately, including mid-transfer.
  - On reset release, the first accept is possible on the first rising edge.
- Target index tgt:
  - auto_en=0: tgt = {S2,S1}. 00->O1, 01->O2, 10->O3, 11->O4. This matches the mux pairing: S1 picks within a pair, S2 picks the pair.
  - auto_en=1: tgt = ptr.
  - tgt is evaluated combinationally every cycle. A select change while I_valid is high and I_ready is low simply retargets; no word is latched on the input side.
- Channel buffer: each channel is a 1-entry register with a valid flag.
  - Slot x is free when Ox_valid=0 or Ox_ready=1.
  - I_ready = free(tgt). It does not depend on I_valid.
- Accept = I_valid & I_ready, sampled at the rising edge:
  - O[tgt] <= I, O[tgt]_valid <= 1.
  - acc_cnt increments, wrapping 2^CNT_W-1 -> 0.
  - If auto_en=1, ptr <= ptr+1, wrapping 3 -> 0.
- Latency: a word accepted at edge n is visible on Ox with Ox_valid=1 after edge n.
- Drain: Ox_valid & Ox_ready at an edge with no accept into that slot -> Ox_valid <= 0. Ox keeps its last value; data is not cleared.
- Simultaneous drain and accept on the same slot: new word replaces old, Ox_valid stays 1, full throughput of 1 word/cycle per channel.
- Other channels drain independently in the same cycle as an accept elsewhere.
- ptr holds while auto_en=0. When auto_en goes 0->1, the pointer resumes from its held value. ptr only advances on an accept with auto_en=1.
- Blocked target: if the target is full and its consumer is not ready, I_ready=0 and no state changes except drains on other channels.
- Ox_ready on an empty channel is ignored.

Test Plan:
- Reset/idle: assert rst_n=0 mid-stream with O2_valid=1 -> all valids 0, O1..O4=0, ptr=0, acc_cnt=0 without waiting for a clock edge.
- Manual routing: auto_en=0, all Ox_ready=0. Send 0xA001 with S2S1=00, 0xA002 with 01, 0xA003 with 10, 0xA004 with 11 on 4 consecutive cycles -> O1..O4 = 0xA001..0xA004, all valids 1, acc_cnt=4.
- Backpressure: O3 full, O3_ready=0, S2S1=10, I_valid=1 -> I_ready=0 for 5 cycles and O3 unchanged. Raise O3_ready -> same cycle I_ready=1, new word replaces O3, O3_valid stays 1.
- Round-robin wrap: auto_en=1, all Ox_ready=1, stream 0x0000..0x0005 -> words land on O1,O2,O3,O4,O1,O2 in order, ptr sequence 0,1,2,3,0,1,2.
- Pointer hold: auto_en=1 with ptr=2, drop auto_en to 0 and send 3 manual words to O1, re-enable -> next word goes to O3, then ptr=3.
- Counter wrap and drain: accept 256 words -> acc_cnt=0. Drain O1 with no refill -> O1_valid=0, O1 data unchanged.
